seq_mul_shift_add: RTL and testbench

Parametrised sequential unsigned multiplier with a datapath and FSM controller. It replaces the repeated-addition 16-bit multiplier with a shift-and-add engine that takes at most WIDTH iterations.
- Operands arrive serially, A then B, on one shared data_in bus.
- The full 2*WIDTH-bit product is presented with a done flag.
- The block sits beside the GCD/MUL arithmetic units and uses the same start/done control style.

---
 rtl/seq_mul_shift_add.sv | 93 +++++++++
 tb/tb_seq_mul_shift_add.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_shift_add.sv
// Shift-and-add unsigned multiplier, operands A then B on data_in; WIDTH RUN cycles, or fewer with EARLY_TERM_EN.
// Operands are accepted only while in_ready is high; start is ignored while busy.
module seq_mul_shift_add #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]         state;
  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;

  always_comb begin
    acc_next = acc;
    if (b_reg[0]) acc_next = acc + a_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) state <= S_LOAD_A;
        end
        S_LOAD_A: begin
          if (in_valid) begin
            a_reg <= {{WIDTH{1'b0}}, data_in};
            state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (in_valid) begin
            b_reg <= data_in;
            acc   <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef EARLY_TERM_EN
          // No multiplier bits left: the accumulator already holds the product.
          if (b_reg == '0) begin
            product <= acc;
            state   <= S_DONE;
          end else
`endif
          begin
            acc   <= acc_next;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST_CNT) begin
              product <= acc_next;
              state   <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign busy     = in_ready || (state == S_RUN);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Randomised and directed checks of seq_mul_shift_add at WIDTH=16 and WIDTH=8 against arithmetic expectations.
module tb_seq_mul_shift_add;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, busy, done;
  logic [31:0] product;

  logic        start8 = 1'b0;
  logic [7:0]  data8 = '0;
  logic        in_valid8 = 1'b0;
  logic        in_ready8, busy8, done8;
  logic [15:0] product8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_mul_shift_add #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .done(done), .product(product)
  );

  seq_mul_shift_add #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .data_in(data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .busy(busy8), .done(done8), .product(product8)
  );

  // Expected RUN length: fixed WIDTH, or up to the last set multiplier bit plus one idle check.
  function automatic int exp_lat(input logic [15:0] b, input int w);
    int msb;
`ifdef EARLY_TERM_EN
    if (b == 0) return 1;
    msb = 0;
    for (int i = 0; i < w; i++) if (b[i]) msb = i;
    return (msb + 2 < w) ? msb + 2 : w;
`else
    msb = b;
    return w;
`endif
  endfunction

  // Drives one full operation on the 16-bit instance and reports what it observed.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int sa, input int sb,
                       input bit junk_iv, input bit stray,
                       output logic [31:0] prod, output int lat, output logic [31:0] prod_before,
                       output logic done_mid, output logic busy_done);
    @(negedge clk);
    start = 1'b1; in_valid = junk_iv; data_in = junk_iv ? 16'd99 : 16'd0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    done_mid = done;
    repeat (sa) @(negedge clk);
    data_in = a; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (sb) @(negedge clk);
    data_in = b; in_valid = 1'b1;
    prod_before = product;
    @(posedge clk); #1;
    in_valid = 1'b0; data_in = '0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (stray && n == 3) begin start = 1'b1; in_valid = 1'b1; data_in = 16'($urandom); end
      if (stray && n == 4) begin start = 1'b0; in_valid = 1'b0; end
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    start = 1'b0; in_valid = 1'b0;
    prod = product;
    busy_done = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (product !== 32'd0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: product=%h done=%b busy=%b in_ready=%b, want 0/0/0/0", product, done, busy, in_ready);
    end
    checks++;
    if (product8 !== 16'd0 || done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_w8: product=%h done=%b busy=%b, want 0/0/0", product8, done8, busy8);
    end
    @(negedge clk); rst = 1'b0;
    in_valid = 1'b1; data_in = 16'd55;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_in_valid: busy=%b in_ready=%b done=%b, want 0/0/0", busy, in_ready, done);
    end
  endtask

  task automatic run_and_check(input string name, input logic [15:0] a, input logic [15:0] b,
                               input int sa, input int sb, input bit junk, input bit stray);
    logic [31:0] p, pb; int lat; logic dm, bd;
    do_op(a, b, sa, sb, junk, stray, p, lat, pb, dm, bd);
    checks++;
    if (p !== 32'(a) * 32'(b)) begin
      errors++;
      $display("FAIL %s_product: got %h, want %h", name, p, 32'(a) * 32'(b));
    end
    checks++;
    if (lat != exp_lat(b, 16)) begin
      errors++;
      $display("FAIL %s_latency: got %0d, want %0d", name, lat, exp_lat(b, 16));
    end
    checks++;
    if (bd !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_in_done: got %b, want 0", name, bd);
    end
  endtask

  task automatic test_directed();
    run_and_check("a17_b5", 16'd17, 16'd5, 0, 0, 1'b0, 1'b0);
    run_and_check("ffff_sq", 16'hFFFF, 16'hFFFF, 0, 0, 1'b0, 1'b0);
    run_and_check("b_zero", 16'd1234, 16'd0, 0, 0, 1'b0, 1'b0);
    run_and_check("a_zero", 16'd0, 16'd1234, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stalls();
    run_and_check("stall_9x7", 16'd9, 16'd7, 3, 2, 1'b0, 1'b0);
    run_and_check("start_with_iv", 16'd21, 16'd3, 0, 0, 1'b1, 1'b0);
    run_and_check("stray_in_run", 16'd1000, 16'h8123, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      b = 16'($urandom) >> $urandom_range(0, 15);
      run_and_check("random", a, b, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    data_in = 16'd300; in_valid = 1'b1;
    @(negedge clk); data_in = 16'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (product !== 32'd0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset: product=%h done=%b busy=%b in_ready=%b, want 0/0/0/0", product, done, busy, in_ready);
    end
    rst = 1'b0;
    run_and_check("after_reset_3x4", 16'd3, 16'd4, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] p, pb; int lat; logic dm, bd;
    run_and_check("b2b_first", 16'd17, 16'd5, 0, 0, 1'b0, 1'b0);
    do_op(16'd6, 16'd7, 0, 0, 1'b0, 1'b0, p, lat, pb, dm, bd);
    checks++;
    if (pb !== 32'd85) begin
      errors++;
      $display("FAIL b2b_hold_old: got %h, want %h", pb, 32'd85);
    end
    checks++;
    if (dm !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_low: got %b, want 0", dm);
    end
    checks++;
    if (p !== 32'd42 || lat != exp_lat(16'd7, 16)) begin
      errors++;
      $display("FAIL b2b_second: product=%h lat=%0d, want %h lat=%0d", p, lat, 32'd42, exp_lat(16'd7, 16));
    end
  endtask

  task automatic test_width8();
    logic [7:0] a, b;
    int lat;
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 8'hFF : 8'($urandom);
      b = (k == 0) ? 8'hFF : 8'($urandom);
      @(negedge clk); start8 = 1'b1;
      @(negedge clk); start8 = 1'b0; data8 = a; in_valid8 = 1'b1;
      @(negedge clk); data8 = b;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk); #1;
        if (done8) begin lat = n; break; end
      end
      checks++;
      if (product8 !== 16'(a) * 16'(b) || lat != exp_lat(16'(b), 8)) begin
        errors++;
        $display("FAIL w8_product: product=%h lat=%0d, want %h lat=%0d", product8, lat, 16'(a) * 16'(b), exp_lat(16'(b), 8));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stalls();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
